// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - multi-channel clock-gating controller with wake latency and idle hysteresis
module clk_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 4,
  parameter int RESET_ON    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH-1:0]              force_on,
  output logic [NUM_CH-1:0]              gate_en,
  output logic [NUM_CH-1:0]              clk_gated,
  output logic [NUM_CH-1:0]              ready,
  output logic [$clog2(NUM_CH+1)-1:0]    active_count
);

  typedef enum logic [1:0] {OFF, WAKE, ON, IDLE} state_t;

  localparam int AC_W = $clog2(NUM_CH+1);
  localparam logic [CNT_W-1:0] WAKE_INIT = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] IDLE_INIT = CNT_W'(IDLE_CYCLES - 1);

  state_t            state [NUM_CH];
  logic [CNT_W-1:0]  cnt   [NUM_CH];
  logic [NUM_CH-1:0] act;
  logic [NUM_CH-1:0] gate_nxt;
  logic [NUM_CH-1:0] en_lat;
  logic [AC_W-1:0]   count_nxt;

  assign act = req | force_on;

  // Next gate_en is needed ahead of the edge so active_count registers together with it.
  always_comb begin
    gate_nxt  = '0;
    count_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (state[i])
        OFF:     gate_nxt[i] = act[i];
        IDLE:    gate_nxt[i] = act[i] || (cnt[i] != '0);
        default: gate_nxt[i] = 1'b1;
      endcase
      count_nxt = count_nxt + AC_W'(gate_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= (RESET_ON != 0) ? ON : OFF;
        cnt[i]   <= '0;
      end
      gate_en      <= {NUM_CH{RESET_ON != 0}};
      ready        <= {NUM_CH{RESET_ON != 0}};
      active_count <= (RESET_ON != 0) ? AC_W'(NUM_CH) : '0;
    end else begin
      gate_en      <= gate_nxt;
      active_count <= count_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        case (state[i])
          OFF: begin
            if (act[i]) begin
              if (WAKE_CYCLES == 0) begin
                state[i] <= ON;
                ready[i] <= 1'b1;
              end else begin
                state[i] <= WAKE;
                cnt[i]   <= WAKE_INIT;
              end
            end
          end
          WAKE: begin
            if (cnt[i] == '0) begin
              state[i] <= ON;
              ready[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
          ON: begin
            if (!act[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= IDLE_INIT;
            end
          end
          IDLE: begin
            // A request on the final idle cycle wins over the shutdown.
            if (act[i]) begin
              state[i] <= ON;
            end else if (cnt[i] == '0) begin
              state[i] <= OFF;
              ready[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
          default: state[i] <= OFF;
        endcase
      end
    end
  end

  // Latch is transparent only while clk is low, so enable changes never clip a high phase.
  always_latch begin
    if (!clk) en_lat <= gate_en;
  end

  assign clk_gated = {NUM_CH{clk}} & en_lat;

endmodule
